load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the core's EXECUTE state.
- Consumes the effective address (rs1+Iimm or rs1+Simm), funct3 and rs2 data for LOAD/STORE opcodes.
- Performs the single word access on the data memory port with byte-lane masking, alignment checking and load sign/zero extension.
- Returns the write-back value or an error flag to the core, which holds its FSM until the response arrives.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT before the access is aborted with error. Range 1..255; the counter is 8 bits.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  core presents a load/store request.
- req_ready  output  1  unit idle and able to accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 of the LOAD/STORE instruction.
- req_addr  input  32  effective byte address.
- req_wdata  input  32  rs2 value (stores).
- rsp_valid  output  1  one-cycle pulse; response fields valid.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned address, illegal funct3, or timeout.
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
- mem_wdata  output  32  lane-replicated store data.
- mem_wmask  output  4  byte write enables; nonzero for exactly one cycle per store.
- mem_rstrb  output  1  read strobe; one cycle per load.
- mem_rdata  input  32  read word; valid when mem_rbusy is low in WAIT.
- mem_rbusy  input  1  read in progress.
- mem_wbusy  input  1  write in progress.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE and the timeout counter clears.
  - All outputs are 0, including req_ready, and mem strobes/mask drop immediately.
  - A request in flight is discarded with no response.
- req_ready is registered. It is 1 from the first clk edge after reset release while in IDLE, and 0 in all other states.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - When req_valid & req_ready, latch we, funct3, addr and wdata.
  - If the request is legal and aligned, go to ISSUE.
  - Otherwise set rsp_err=1 and go to RESP with no memory access.
- Legality rules:
  - Loads: funct3 must be 000 LB, 001 LH, 010 LW, 100 LBU or 101 LHU.
  - Stores: funct3 must be 000 SB, 001 SH or 010 SW.
  - Any other funct3 is illegal.
  - Halfword access needs addr[0]=0; word access needs addr[1:0]=0.
- ISSUE (exactly 1 cycle):
  - Load: mem_rstrb=1.
  - Store: mem_wmask = 0001<<a for byte, 0011<<a for halfword, 1111 for word, where a = addr[1:0].
  - Store data: mem_wdata = {4{b}} for byte, {2{h}} for halfword, wdata for word.
  - mem_addr is held stable from ISSUE through WAIT.
  - Next state is WAIT and the counter clears.
- WAIT:
  - If the relevant busy line (rbusy for loads, wbusy for stores) is low, sample mem_rdata and go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES, set rsp_err=1 and go to RESP.
  - When busy falls on the same cycle the counter hits the limit, completion wins (no error).
- RESP:
  - rsp_valid=1 for exactly one cycle, then go to IDLE.
  - req_ready rises on the following edge, so back-to-back requests have a one-cycle gap.
- Load extraction, by funct3 (lane select = addr[1:0]):
  - LB: byte lane addr[1:0], sign-extended.
  - LBU: byte lane addr[1:0], zero-extended.
  - LH: halfword lane addr[1], sign-extended.
  - LHU: halfword lane addr[1], zero-extended.
  - LW: the full word.
- Latency with a zero-wait memory: accept at edge N, ISSUE N+1, WAIT N+2, rsp_valid high in cycle N+3. Error path: rsp_valid in cycle N+1.
- req_valid deasserted outside IDLE is ignored. Request inputs need only be stable on the accept cycle.

Decomposition:
- Shared package holds:
  - FSM state encodings.
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - Opcode constants LOAD=0000011 and STORE=0100011, shared with the decoder.
- One natural combinational sub-module, lsu_align, holds store mask/replication and load extract/extend. It is used twice: once at ISSUE and once at the WAIT capture.

Test Plan:
- Reset mid-WAIT (mem_rbusy held 1), then reset released: no rsp_valid, all outputs 0; req_ready=1 one edge after release.
- SW addr=0x10 wdata=0xDEADBEEF with zero-wait memory -> mem_addr=0x10, mem_wmask=1111 for one cycle, rsp_valid at N+3, rsp_rdata=0, rsp_err=0.
- SB addr=0x13 wdata=0x000000A5 -> mem_wmask=1000, mem_wdata=0xA5A5A5A5.
- Memory word 0x80FF7F01 at 0x20:
  - LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080.
  - LH 0x20 -> 0x00007F01; LHU 0x22 -> 0x000080FF.
- LW addr=0x22, then LH addr=0x21, then funct3=011 -> each gives rsp_err=1 at N+1, with no mem_rstrb or mem_wmask activity.
- LW with mem_rbusy held 1 for TIMEOUT_CYCLES=4:
  - Limit reached -> rsp_err=1.
  - Repeat with rbusy falling on the limit cycle, data 0x12345678 -> rsp_err=0, rsp_rdata=0x12345678.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 and opcode
// encodings, and the access-legality rule.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    // Unsigned widths exist only for loads; halfwords need even, words need
    // 4-byte aligned addresses.
    function automatic logic access_ok(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~lo[0];
            F3_W:    ok = (lo == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & ~lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store mask and data replication, plus load lane
// extraction with sign/zero extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        wmask = 4'b1111;
        wdata = store_data;
        case (funct3)
            F3_B: begin
                wmask = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                wmask = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        lane_b = load_word[7:0];
        case (offset)
            2'd0: lane_b = load_word[7:0];
            2'd1: lane_b = load_word[15:8];
            2'd2: lane_b = load_word[23:16];
            2'd3: lane_b = load_word[31:24];
            default: lane_b = load_word[7:0];
        endcase
        lane_h = offset[1] ? load_word[31:16] : load_word[15:0];
        case (funct3)
            F3_B:    rdata = {{24{lane_b[7]}}, lane_b};
            F3_BU:   rdata = {24'b0, lane_b};
            F3_H:    rdata = {{16{lane_h[15]}}, lane_h};
            F3_HU:   rdata = {16'b0, lane_h};
            default: rdata = load_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one aligned data-memory access per request, with an
// error response for illegal/misaligned requests and memory timeouts.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    input  logic        mem_wbusy
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    lsu_state_t  state, next_state;
    logic        ready_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;

    logic        accept;
    logic        legal;
    logic        busy;
    logic        done;
    logic        expired;

    logic [3:0]  st_wmask;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic [31:0] st_rdata_unused;
    logic [3:0]  ld_wmask_unused;
    logic [31:0] ld_wdata_unused;

    // Store side steers the latched request; load side steers the returning word.
    lsu_align u_store_align (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .store_data (wdata_q),
        .load_word  (32'b0),
        .wmask      (st_wmask),
        .wdata      (st_wdata),
        .rdata      (st_rdata_unused)
    );

    lsu_align u_load_align (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .store_data (32'b0),
        .load_word  (mem_rdata),
        .wmask      (ld_wmask_unused),
        .wdata      (ld_wdata_unused),
        .rdata      (ld_data)
    );

    assign accept  = req_valid & ready_q & (state == ST_IDLE);
    assign legal   = access_ok(req_we, req_funct3, req_addr[1:0]);
    assign busy    = we_q ? mem_wbusy : mem_rbusy;
    assign cnt_inc = cnt + 8'd1;
    assign done    = (state == ST_WAIT) & ~busy;
    assign expired = (state == ST_WAIT) & busy & (cnt_inc == LIMIT);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept) next_state = legal ? ST_ISSUE : ST_RESP;
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT:  if (done || expired) next_state = ST_RESP;
            ST_RESP:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Ready follows the next state, so it stays low on the first cycle after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'b0;
            cnt      <= 8'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == ST_IDLE);
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                err_q    <= ~legal;
                rdata_q  <= 32'b0;
            end
            if (state == ST_ISSUE)
                cnt <= 8'b0;
            else if ((state == ST_WAIT) && busy)
                cnt <= cnt_inc;
            if (done)
                rdata_q <= we_q ? 32'b0 : ld_data;
            if (expired)
                err_q <= 1'b1;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = (state == ST_RESP) ? rdata_q : 32'b0;
    assign rsp_err   = (state == ST_RESP) & err_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_rstrb = (state == ST_ISSUE) & ~we_q;
    assign mem_wmask = ((state == ST_ISSUE) && we_q) ? st_wmask : 4'b0;
    assign mem_wdata = ((state == ST_ISSUE) && we_q) ? st_wdata : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 4-cycle timeout.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;

    int n_checks;
    int n_fail;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rstrb  (mem_rstrb),
        .mem_rdata  (mem_rdata),
        .mem_rbusy  (mem_rbusy),
        .mem_wbusy  (mem_wbusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic apply_stimulus(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] exp);
        apply_stimulus(1'b0, f3, addr, 32'h0);
        check_output({tag, "_rstrb"}, {31'b0, mem_rstrb}, 32'd1);
        check_output({tag, "_maddr"}, mem_addr, 32'h20);
        step();
        step();
        check_output({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        check_output({tag, "_rdata"}, rsp_rdata, exp);
        step();
    endtask

    task automatic do_illegal(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        apply_stimulus(1'b0, f3, addr, 32'h0);
        check_output({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        check_output({tag, "_err"}, {31'b0, rsp_err}, 32'd1);
        check_output({tag, "_rdata"}, rsp_rdata, 32'h0);
        check_output({tag, "_strobes"}, {27'b0, mem_rstrb, mem_wmask}, 32'h0);
        step();
        check_output({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_rdata  = 32'h0;
        mem_rbusy  = 1'b0;
        mem_wbusy  = 1'b0;

        step();
        check_output("rst_ready", {31'b0, req_ready}, 32'd0);
        check_output("rst_valid", {31'b0, rsp_valid}, 32'd0);
        reset = 1'b1;
        #1;
        check_output("rel_ready_before_edge", {31'b0, req_ready}, 32'd0);
        step();
        check_output("rel_ready", {31'b0, req_ready}, 32'd1);

        // Reset in the middle of a stalled load.
        mem_rbusy = 1'b1;
        apply_stimulus(1'b0, 3'b010, 32'h20, 32'h0);
        check_output("mw_rstrb", {31'b0, mem_rstrb}, 32'd1);
        step();
        check_output("mw_wait_addr", mem_addr, 32'h20);
        check_output("mw_wait_rstrb", {31'b0, mem_rstrb}, 32'd0);
        reset = 1'b0;
        #1;
        check_output("mw_rst_outs", {mem_addr[27:0], rsp_valid, req_ready, rsp_err, mem_rstrb}, 32'h0);
        step();
        step();
        check_output("mw_rst_valid", {31'b0, rsp_valid}, 32'd0);
        mem_rbusy = 1'b0;
        reset = 1'b1;
        #1;
        check_output("mw_rel_ready0", {31'b0, req_ready}, 32'd0);
        step();
        check_output("mw_rel_ready1", {31'b0, req_ready}, 32'd1);
        check_output("mw_rel_valid", {31'b0, rsp_valid}, 32'd0);

        // Word store with a zero-wait memory.
        apply_stimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        check_output("sw_addr", mem_addr, 32'h10);
        check_output("sw_mask", {28'b0, mem_wmask}, 32'hF);
        check_output("sw_wdata", mem_wdata, 32'hDEADBEEF);
        check_output("sw_ready_busy", {31'b0, req_ready}, 32'd0);
        step();
        check_output("sw_mask_off", {28'b0, mem_wmask}, 32'h0);
        check_output("sw_valid_early", {31'b0, rsp_valid}, 32'd0);
        step();
        check_output("sw_valid", {31'b0, rsp_valid}, 32'd1);
        check_output("sw_rdata", rsp_rdata, 32'h0);
        check_output("sw_err", {31'b0, rsp_err}, 32'd0);
        check_output("sw_ready_resp", {31'b0, req_ready}, 32'd0);
        step();
        check_output("sw_valid_pulse", {31'b0, rsp_valid}, 32'd0);
        check_output("sw_ready_after", {31'b0, req_ready}, 32'd1);

        apply_stimulus(1'b1, 3'b000, 32'h13, 32'h000000A5);
        check_output("sb_mask", {28'b0, mem_wmask}, 32'h8);
        check_output("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        check_output("sb_addr", mem_addr, 32'h10);
        step();
        step();
        check_output("sb_err", {31'b0, rsp_err}, 32'd0);
        step();

        apply_stimulus(1'b1, 3'b001, 32'h16, 32'h1234BEEF);
        check_output("sh_mask", {28'b0, mem_wmask}, 32'hC);
        check_output("sh_wdata", mem_wdata, 32'hBEEFBEEF);
        step();
        step();
        step();

        mem_rdata = 32'h80FF7F01;
        do_load("lb",  3'b000, 32'h23, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h23, 32'h00000080);
        do_load("lh",  3'b001, 32'h20, 32'h00007F01);
        do_load("lhu", 3'b101, 32'h22, 32'h000080FF);
        do_load("lw",  3'b010, 32'h20, 32'h80FF7F01);

        do_illegal("lw_mis", 3'b010, 32'h22);
        do_illegal("lh_mis", 3'b001, 32'h21);
        do_illegal("f3_011", 3'b011, 32'h20);

        // Timeout: busy for the whole limit.
        mem_rbusy = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        apply_stimulus(1'b0, 3'b010, 32'h40, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_output($sformatf("to_wait%0d", i), {31'b0, rsp_valid}, 32'd0);
        end
        step();
        check_output("to_valid", {31'b0, rsp_valid}, 32'd1);
        check_output("to_err", {31'b0, rsp_err}, 32'd1);
        check_output("to_rdata", rsp_rdata, 32'h0);
        step();

        // Busy drops on the limit cycle: completion wins.
        apply_stimulus(1'b0, 3'b010, 32'h40, 32'h0);
        for (int i = 0; i < 4; i++) step();
        mem_rbusy = 1'b0;
        mem_rdata = 32'h12345678;
        step();
        check_output("lim_valid", {31'b0, rsp_valid}, 32'd1);
        check_output("lim_err", {31'b0, rsp_err}, 32'd0);
        check_output("lim_rdata", rsp_rdata, 32'h12345678);
        step();
        check_output("lim_ready", {31'b0, req_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
